// File: rtl/testio_mlane_if.sv
// Request/response bus of the multi-lane test-IO master.
// The requester drives the master modport; testio_mlane sits on the slave modport.
interface testio_mlane_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic [15:0] req_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_err;
  logic [15:0] resp_tag;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_err, resp_tag, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_tag, resp_ready,
    output req_ready, resp_valid, resp_err, resp_tag, resp_rdata
  );
endinterface

// File: rtl/testio_mlane.sv
// Multi-lane serial test-IO master: sends command/address/data words over LANES pins,
// then waits for the target's start beat, ACK, optional read data and parity.
module testio_mlane #(
  parameter int unsigned LANES   = 1,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic               ti_clk_i,
  input  logic               ti_rstn_i,
  testio_mlane_if.slave      bus,
  input  logic [LANES-1:0]   ti_dat_i,
  output logic [LANES-1:0]   ti_dat_o,
  output logic [LANES-1:0]   ti_dat_oen,
  output logic               ti_clk_o,
  output logic               ti_clk_oen,
  output logic               ti_busy_o,
  output logic [7:0]         err_cnt_o
);

  localparam int unsigned Beats    = 32 / LANES;
  localparam logic [4:0]  LastBeat = 5'(Beats - 1);
  localparam logic [15:0] LastWait = 16'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle, StCmd, StAddr, StData, StTurn, StWait, StAck, StRdata, StParity, StResp
  } state_e;

  state_e      r_state, w_state_nxt;
  logic        r_write, w_write_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic [15:0] r_tag, w_tag_nxt;
  logic [31:0] r_shift, w_shift_nxt;
  logic [4:0]  r_bcnt, w_bcnt_nxt;
  logic [15:0] r_wcnt, w_wcnt_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;
  logic        r_resp_err, w_resp_err_nxt;
  logic [31:0] r_resp_rdata, w_resp_rdata_nxt;
  logic [7:0]  r_err_cnt, w_err_cnt_nxt;
  logic [LANES-1:0] r_dat_o, r_dat_oen;
  logic        w_send;
  logic        w_last_beat;

  assign w_last_beat = (r_bcnt == LastBeat);

  always_comb begin
    w_state_nxt      = r_state;
    w_write_nxt      = r_write;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_tag_nxt        = r_tag;
    w_shift_nxt      = r_shift;
    w_bcnt_nxt       = r_bcnt;
    w_wcnt_nxt       = r_wcnt;
    w_rdata_nxt      = r_rdata;
    w_resp_err_nxt   = r_resp_err;
    w_resp_rdata_nxt = r_resp_rdata;
    w_err_cnt_nxt    = r_err_cnt;
    unique case (r_state)
      StIdle: begin
        if (bus.req_valid) begin
          w_state_nxt    = StCmd;
          w_write_nxt    = bus.req_write;
          w_addr_nxt     = bus.req_addr;
          w_wdata_nxt    = bus.req_wdata;
          w_tag_nxt      = bus.req_tag;
          w_shift_nxt    = {bus.req_write, 27'b0, bus.req_strb};
          w_bcnt_nxt     = '0;
          w_resp_err_nxt = 1'b0;
        end
      end
      StCmd, StAddr, StData: begin
        w_shift_nxt = r_shift >> LANES;
        w_bcnt_nxt  = r_bcnt + 5'd1;
        if (w_last_beat) begin
          w_bcnt_nxt = '0;
          if (r_state == StCmd) begin
            w_state_nxt = StAddr;
            w_shift_nxt = r_addr;
          end else if (r_state == StAddr && r_write) begin
            w_state_nxt = StData;
            w_shift_nxt = r_wdata;
          end else begin
            w_state_nxt = StTurn;
          end
        end
      end
      StTurn: begin
        w_state_nxt = StWait;
        w_wcnt_nxt  = '0;
      end
      StWait: begin
        // An all-low beat from the target is its start marker.
        if (ti_dat_i == '0) begin
          w_state_nxt = StAck;
        end else if (r_wcnt == LastWait) begin
          w_state_nxt      = StResp;
          w_resp_err_nxt   = 1'b1;
          w_resp_rdata_nxt = '1;
        end else begin
          w_wcnt_nxt = r_wcnt + 16'd1;
        end
      end
      StAck: begin
        if (!ti_dat_i[0]) begin
          w_state_nxt      = StResp;
          w_resp_err_nxt   = 1'b1;
          w_resp_rdata_nxt = '1;
        end else if (r_write) begin
          w_state_nxt      = StResp;
          w_resp_rdata_nxt = '0;
        end else begin
          w_state_nxt = StRdata;
          w_bcnt_nxt  = '0;
          w_rdata_nxt = '0;
        end
      end
      StRdata: begin
        // Beats arrive LSB-first: shift right and insert the new beat at the top.
        w_rdata_nxt = (r_rdata >> LANES) | (32'(ti_dat_i) << (32 - LANES));
        w_bcnt_nxt  = r_bcnt + 5'd1;
        if (w_last_beat) begin
          w_state_nxt = StParity;
          w_bcnt_nxt  = '0;
        end
      end
      StParity: begin
        w_state_nxt = StResp;
        if (ti_dat_i[0] != ^r_rdata) begin
          w_resp_err_nxt   = 1'b1;
          w_resp_rdata_nxt = '1;
        end else begin
          w_resp_rdata_nxt = r_rdata;
        end
      end
      StResp: begin
        if (bus.resp_ready) begin
          w_state_nxt = StIdle;
          if (r_resp_err && r_err_cnt != 8'hFF) begin
            w_err_cnt_nxt = r_err_cnt + 8'd1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge ti_clk_i or negedge ti_rstn_i) begin
    if (!ti_rstn_i) begin
      r_state      <= StIdle;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_tag        <= '0;
      r_shift      <= '0;
      r_bcnt       <= '0;
      r_wcnt       <= '0;
      r_rdata      <= '0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '1;
      r_err_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_write      <= w_write_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_tag        <= w_tag_nxt;
      r_shift      <= w_shift_nxt;
      r_bcnt       <= w_bcnt_nxt;
      r_wcnt       <= w_wcnt_nxt;
      r_rdata      <= w_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
    end
  end

  assign w_send = (r_state == StCmd) || (r_state == StAddr) || (r_state == StData);

  // Pins launch on the falling edge so the target sees them stable around its rising edge.
  always_ff @(negedge ti_clk_i or negedge ti_rstn_i) begin
    if (!ti_rstn_i) begin
      r_dat_o   <= '1;
      r_dat_oen <= '1;
    end else if (w_send) begin
      r_dat_o   <= r_shift[LANES-1:0];
      r_dat_oen <= '0;
    end else begin
      r_dat_o   <= '1;
      r_dat_oen <= '1;
    end
  end

  assign bus.req_ready  = (r_state == StIdle) && ti_rstn_i;
  assign bus.resp_valid = (r_state == StResp);
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_tag   = r_tag;
  assign bus.resp_rdata = r_resp_rdata;

  assign ti_dat_o   = r_dat_o;
  assign ti_dat_oen = r_dat_oen;
  assign ti_clk_o   = ti_clk_i;
  assign ti_clk_oen = 1'b0;
  assign ti_busy_o  = (r_state != StIdle);
  assign err_cnt_o  = r_err_cnt;

endmodule

// File: tb/tb_testio_mlane.sv
// Directed bench for testio_mlane: three instances (LANES 1, 8, 4; TIMEOUT 16) driven by a
// behavioural target, with hand-computed expected responses.
module tb_testio_mlane;
  localparam int unsigned NDut = 3;
  localparam int unsigned Tmo  = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NDut-1:0] req_valid, req_write, resp_ready;
  logic [31:0]     req_addr  [NDut];
  logic [31:0]     req_wdata [NDut];
  logic [3:0]      req_strb  [NDut];
  logic [15:0]     req_tag   [NDut];
  logic [31:0]     dat_i     [NDut];

  logic [NDut-1:0] req_ready, resp_valid, resp_err, busy, clk_o, clk_oen;
  logic [15:0]     resp_tag   [NDut];
  logic [31:0]     resp_rdata [NDut];
  logic [31:0]     dat_o      [NDut];
  logic [31:0]     dat_oen    [NDut];
  logic [7:0]      err_cnt    [NDut];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  int unsigned rise_cyc [NDut];
  logic        rv_prev  [NDut];
  logic [7:0]  exp_cnt  [NDut];

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    localparam int unsigned Ln = (g == 0) ? 1 : ((g == 1) ? 8 : 4);
    testio_mlane_if u_if ();
    logic [Ln-1:0] w_dat_o, w_dat_oen;
    assign u_if.req_valid  = req_valid[g];
    assign u_if.req_write  = req_write[g];
    assign u_if.req_addr   = req_addr[g];
    assign u_if.req_wdata  = req_wdata[g];
    assign u_if.req_strb   = req_strb[g];
    assign u_if.req_tag    = req_tag[g];
    assign u_if.resp_ready = resp_ready[g];
    assign req_ready[g]    = u_if.req_ready;
    assign resp_valid[g]   = u_if.resp_valid;
    assign resp_err[g]     = u_if.resp_err;
    assign resp_tag[g]     = u_if.resp_tag;
    assign resp_rdata[g]   = u_if.resp_rdata;
    assign dat_o[g]        = 32'(w_dat_o);
    assign dat_oen[g]      = 32'(w_dat_oen);
    testio_mlane #(.LANES(Ln), .TIMEOUT(Tmo)) u_dut (
      .ti_clk_i   (clk),
      .ti_rstn_i  (rstn),
      .bus        (u_if.slave),
      .ti_dat_i   (dat_i[g][Ln-1:0]),
      .ti_dat_o   (w_dat_o),
      .ti_dat_oen (w_dat_oen),
      .ti_clk_o   (clk_o[g]),
      .ti_clk_oen (clk_oen[g]),
      .ti_busy_o  (busy[g]),
      .err_cnt_o  (err_cnt[g])
    );
  end

  function automatic int lanes_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 8 : 4);
  endfunction

  function automatic logic [31:0] lane_mask(input int d);
    return (32'd1 << lanes_of(d)) - 32'd1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Cycle counter and first-cycle-of-resp_valid recorder, sampled just after each rising edge.
  initial begin
    for (int d = 0; d < NDut; d++) begin
      rv_prev[d]  = 1'b0;
      rise_cyc[d] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < NDut; d++) begin
        if (resp_valid[d] && !rv_prev[d]) rise_cyc[d] = cyc;
        rv_prev[d] = resp_valid[d];
      end
    end
  end

  // Issue one request, check the pins, play the target, and check the response (left pending).
  task automatic run_txn(input int d, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb, input logic [15:0] tag,
                         input int wait_n, input logic ack, input logic [31:0] rd, input logic par,
                         input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
    int ln, nb, nsend, n, oen_bad;
    int unsigned acc_cyc;
    logic [31:0] w [3];
    ln = lanes_of(d);
    nb = 32 / ln;
    nsend = wr ? 3 * nb : 2 * nb;
    oen_bad = 0;
    for (int k = 0; k < 3; k++) w[k] = '0;
    @(posedge clk);
    #2;
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_strb[d]  = strb;
    req_tag[d]   = tag;
    n = 0;
    while (!req_ready[d] && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_eq("req_ready", req_ready[d], 1);
    @(posedge clk);
    #2;
    acc_cyc = cyc;
    req_valid[d] = 1'b0;
    for (int b = 0; b < nsend; b++) begin
      @(negedge clk);
      #1;
      if (dat_oen[d] !== 32'd0) oen_bad++;
      for (int i = 0; i < ln; i++) w[b / nb][(b % nb) * ln + i] = dat_o[d][i];
    end
    check_eq("send_oen_low", oen_bad, 0);
    check_eq("cmd_word", w[0], {wr, 27'b0, strb});
    check_eq("addr_word", w[1], addr);
    if (wr) check_eq("data_word", w[2], wdata);
    @(negedge clk);
    #1;
    check_eq("turn_oen", dat_oen[d], lane_mask(d));
    check_eq("turn_dat", dat_o[d], lane_mask(d));
    if (wait_n > 0) begin
      for (int c = 0; c < wait_n - 1; c++) @(negedge clk);
      #1;
      @(negedge clk);
      #1;
      dat_i[d] = '0;
      @(negedge clk);
      #1;
      dat_i[d] = ack ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
      if (ack && !wr) begin
        for (int b = 0; b < nb; b++) begin
          @(negedge clk);
          #1;
          dat_i[d] = rd >> (b * ln);
        end
        @(negedge clk);
        #1;
        dat_i[d] = {31'h7FFF_FFFF, par};
      end
      @(negedge clk);
      #1;
      dat_i[d] = '1;
    end
    n = 0;
    while (!resp_valid[d] && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_eq("resp_valid", resp_valid[d], 1);
    check_eq("resp_err", resp_err[d], exp_err);
    check_eq("resp_rdata", resp_rdata[d], exp_rdata);
    check_eq("resp_tag", resp_tag[d], tag);
    check_eq("busy_in_resp", busy[d], 1);
    if (exp_lat > 0) check_eq("latency", rise_cyc[d] - acc_cyc, exp_lat);
  endtask

  task automatic resp_accept(input int d, input logic was_err);
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #2;
    resp_ready[d] = 1'b0;
    if (was_err && exp_cnt[d] != 8'hFF) exp_cnt[d] = exp_cnt[d] + 8'd1;
    check_eq("busy_after", busy[d], 0);
    check_eq("req_ready_after", req_ready[d], 1);
    check_eq("err_cnt", err_cnt[d], exp_cnt[d]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        stable;
    logic        seen;
    logic [31:0] s_rd;
    logic [15:0] s_tag;
    logic        s_err;
    req_valid  = '0;
    req_write  = '0;
    resp_ready = '0;
    for (int d = 0; d < NDut; d++) begin
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_strb[d]  = '0;
      req_tag[d]   = '0;
      dat_i[d]     = '1;
      exp_cnt[d]   = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_req_ready", req_ready[0], 0);
    check_eq("rst_resp_valid", resp_valid[0], 0);
    check_eq("rst_resp_err", resp_err[0], 0);
    check_eq("rst_resp_tag", resp_tag[0], 16'h0000);
    check_eq("rst_resp_rdata", resp_rdata[0], 32'hFFFF_FFFF);
    check_eq("rst_dat_o", dat_o[1], 32'h0000_00FF);
    check_eq("rst_dat_oen", dat_oen[2], 32'h0000_000F);
    check_eq("rst_err_cnt", err_cnt[0], 8'd0);
    check_eq("rst_busy", busy[0], 0);
    check_eq("clk_oen", clk_oen[0], 0);
    check_eq("clk_o", clk_o[0], clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #2;
    check_eq("idle_req_ready", req_ready[0], 1);

    // LANES=1 write, start after 3 WAIT cycles, ACK
    run_txn(0, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 16'h1234, 3, 1'b1, '0, 1'b0,
            1'b0, 32'h0000_0000, 101);
    resp_accept(0, 1'b0);

    // LANES=8 read returning 0x12345678 with parity 1
    run_txn(1, 1'b0, 32'h20, '0, 4'hF, 16'hBEEF, 1, 1'b1, 32'h1234_5678, 1'b1,
            1'b0, 32'h1234_5678, 16);
    resp_accept(1, 1'b0);

    // LANES=4 read with wrong parity
    run_txn(2, 1'b0, 32'h24, '0, 4'h3, 16'h0042, 2, 1'b1, 32'h0000_0001, 1'b0,
            1'b1, 32'hFFFF_FFFF, 29);
    check_eq("err_cnt_pre", err_cnt[2], 8'd0);
    resp_accept(2, 1'b1);

    // Timeout: no start beat for 16 WAIT cycles
    run_txn(1, 1'b0, 32'h28, '0, 4'hF, 16'h7001, 0, 1'b1, '0, 1'b0,
            1'b1, 32'hFFFF_FFFF, 25);
    resp_accept(1, 1'b1);

    // NACK on a write
    run_txn(1, 1'b1, 32'h2C, 32'h0F0F_0F0F, 4'h1, 16'h7002, 2, 1'b0, '0, 1'b0,
            1'b1, 32'hFFFF_FFFF, 16);
    resp_accept(1, 1'b1);

    // Response stalled for 10 cycles
    run_txn(1, 1'b0, 32'h30, '0, 4'hF, 16'h5AA5, 4, 1'b1, 32'h8000_0001, 1'b0,
            1'b0, 32'h8000_0001, 19);
    s_rd   = resp_rdata[1];
    s_tag  = resp_tag[1];
    s_err  = resp_err[1];
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #2;
      if (!resp_valid[1] || resp_rdata[1] !== s_rd || resp_tag[1] !== s_tag ||
          resp_err[1] !== s_err || req_ready[1]) stable = 1'b0;
    end
    check_eq("stall_stable", stable, 1);
    check_eq("stall_rdata", resp_rdata[1], 32'h8000_0001);
    resp_accept(1, 1'b0);

    // Saturation of the error counter
    for (int k = 0; k < 256; k++) begin
      run_txn(1, 1'b0, 32'h40, '0, 4'hF, 16'(k), 1, 1'b0, '0, 1'b0,
              1'b1, 32'hFFFF_FFFF, 11);
      resp_accept(1, 1'b1);
    end
    check_eq("err_cnt_sat", err_cnt[1], 8'd255);

    // Reset pulsed during ADDR on LANES=4
    @(posedge clk);
    #2;
    req_valid[2] = 1'b1;
    req_write[2] = 1'b1;
    req_addr[2]  = 32'h30;
    req_wdata[2] = 32'h55;
    req_strb[2]  = 4'hF;
    req_tag[2]   = 16'h0BAD;
    @(posedge clk);
    #2;
    req_valid[2] = 1'b0;
    repeat (8 + 3) @(negedge clk);
    #1;
    check_eq("mid_busy", busy[2], 1);
    check_eq("mid_oen_low", dat_oen[2], 32'd0);
    rstn = 1'b0;
    #1;
    check_eq("arst_oen", dat_oen[2], 32'h0000_000F);
    check_eq("arst_busy", busy[2], 0);
    check_eq("arst_req_ready", req_ready[2], 0);
    check_eq("arst_rdata", resp_rdata[2], 32'hFFFF_FFFF);
    check_eq("arst_err_cnt", err_cnt[1], 8'd0);
    for (int d = 0; d < NDut; d++) exp_cnt[d] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #2;
      if (resp_valid[2] || busy[2]) seen = 1'b1;
    end
    check_eq("no_resp_after_rst", seen, 0);
    run_txn(2, 1'b1, 32'h44, 32'hDEAD_BEEF, 4'h5, 16'hC0DE, 1, 1'b1, '0, 1'b0,
            1'b0, 32'h0000_0000, 27);
    resp_accept(2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
